// File: rtl/qft_phase_gen.sv
// Sequential QFT angle generator: emits count angles theta_k = 2*pi*(k*step)/2^ACC_W wrapped to [-pi, pi), S3.4.
// Latency: start sampled at cycle T -> first theta_valid at T+2, then 1 angle/cycle while theta_ready=1.
// Backpressure: while theta_valid && !theta_ready the output register, accumulator and load counter all hold.
module qft_phase_gen #(
    parameter int TOTAL_WIDTH = 8,
    parameter int FRAC_BITS   = 4,
    parameter int ACC_W       = 12,
    parameter int CNT_W       = 8,
    parameter int TWOPI_Q     = 25736
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ACC_W-1:0]              step,
    input  logic [CNT_W-1:0]              count,
    output logic                          busy,
    output logic signed [TOTAL_WIDTH-1:0] theta,
    output logic [CNT_W-1:0]              theta_idx,
    output logic                          theta_last,
    output logic                          theta_valid,
    input  logic                          theta_ready,
    output logic                          done
);

    // Product width: signed turn fraction times the 16-bit 2*pi constant.
    localparam int PW = ACC_W + 16;
    // Shift that rescales (turn * 2*pi * 2^12) down to FRAC_BITS fractional bits.
    localparam int SH = ACC_W + 12 - FRAC_BITS;
    localparam logic signed [PW-1:0] TWOPI_S = PW'(TWOPI_Q);
    localparam logic signed [PW-1:0] RND_S   = PW'(2 ** (SH - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                         state_q;
    logic [ACC_W-1:0]               step_q;
    logic [CNT_W-1:0]               count_q;
    logic [ACC_W-1:0]               acc_q;
    logic [CNT_W-1:0]               gen_q;
    logic signed [TOTAL_WIDTH-1:0]  theta_q;
    logic [CNT_W-1:0]               idx_q;
    logic                           last_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           done_q;

    logic signed [PW-1:0]           a_ext;
    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           rnd_sum;
    logic signed [TOTAL_WIDTH-1:0]  theta_d;
    logic [ACC_W-1:0]               acc_d;
    logic [CNT_W-1:0]               gen_d;
    logic                           last_d;
    logic                           load;
    logic                           hs;

    // Binary angle -> radians in S3.4, rounded half up; |result| <= 50 so truncation never overflows.
    always_comb begin
        a_ext   = {{(PW - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        prod    = a_ext * TWOPI_S;
        rnd_sum = prod + RND_S;
        theta_d = TOTAL_WIDTH'(rnd_sum >>> SH);
    end

    // Next accumulator / counter values and the load / handshake qualifiers.
    always_comb begin
        acc_d  = acc_q + step_q;
        gen_d  = gen_q + CNT_W'(1);
        last_d = (gen_d == count_q);
        load   = (!valid_q || theta_ready) && (gen_q != count_q);
        hs     = valid_q && theta_ready;
    end

    // Control FSM with registered stream outputs; start is only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            gen_q   <= '0;
            theta_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        step_q  <= step;
                        count_q <= count;
                        acc_q   <= '0;
                        gen_q   <= '0;
                        busy_q  <= 1'b1;
                        if (count == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (load) begin
                        theta_q <= theta_d;
                        idx_q   <= gen_q;
                        last_q  <= last_d;
                        valid_q <= 1'b1;
                        acc_q   <= acc_d;
                        gen_q   <= gen_d;
                    end else if (hs) begin
                        valid_q <= 1'b0;
                    end
                    if (hs && last_q) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign theta       = theta_q;
    assign theta_idx   = idx_q;
    assign theta_last  = last_q;
    assign theta_valid = valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_qft_phase_gen.sv
// Directed bench for qft_phase_gen: hand-computed angle sequences, backpressure, count==0 and mid-run reset.
// Outputs are sampled on the falling edge; inputs are driven right after that sample.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_qft_phase_gen;

    logic              clk;
    logic              rst;
    logic              start;
    logic [11:0]       step;
    logic [7:0]        count;
    logic              busy;
    logic signed [7:0] theta;
    logic [7:0]        theta_idx;
    logic              theta_last;
    logic              theta_valid;
    logic              theta_ready;
    logic              done;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_th [0:7];

    qft_phase_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .count      (count),
        .busy       (busy),
        .theta      (theta),
        .theta_idx  (theta_idx),
        .theta_last (theta_last),
        .theta_valid(theta_valid),
        .theta_ready(theta_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts a run and consumes it; toggle=1 drives ready with a 1,0,0 pattern.
    task automatic run_stream(input string nm, input logic [11:0] st, input logic [7:0] cnt, input bit toggle);
        int k, cyc, first_v, last_hs, done_cyc, vcyc;
        logic held;
        logic signed [7:0] p_th;
        logic [7:0] p_idx;
        logic p_last;
        k = 0; first_v = -1; last_hs = -1; done_cyc = -1; vcyc = 0;
        held = 1'b0; p_th = '0; p_idx = '0; p_last = 1'b0;
        step  = st;
        count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk({nm, "_busy_after_start"}, busy, 1);
        while (cyc < 80 && done_cyc < 0) begin
            theta_ready = toggle ? ((cyc % 3) == 2) : 1'b1;
            if (done) begin
                done_cyc = cyc;
            end else if (theta_valid) begin
                vcyc++;
                if (first_v < 0) first_v = cyc;
                if (held) begin
                    chk({nm, "_hold_theta"}, theta, p_th);
                    chk({nm, "_hold_idx"}, theta_idx, p_idx);
                    chk({nm, "_hold_last"}, theta_last, p_last);
                end
                if (theta_ready) begin
                    if (k < 8) begin
                        chk({nm, "_theta"}, theta, exp_th[k]);
                        chk({nm, "_idx"}, theta_idx, k);
                        chk({nm, "_last"}, theta_last, (k == int'(cnt) - 1));
                    end
                    k++;
                    last_hs = cyc;
                end
            end
            held   = theta_valid && !theta_ready;
            p_th   = theta;
            p_idx  = theta_idx;
            p_last = theta_last;
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        theta_ready = 1'b1;
        chk({nm, "_num_handshakes"}, k, cnt);
        chk({nm, "_first_valid_cycle"}, first_v, 2);
        chk({nm, "_done_cycle"}, done_cyc, last_hs + 1);
        chk({nm, "_valid_at_done"}, theta_valid, 0);
        chk({nm, "_busy_at_done"}, busy, 1);
        if (!toggle) chk({nm, "_valid_cycles"}, vcyc, cnt);
        tick();
        chk({nm, "_done_cleared"}, done, 0);
        chk({nm, "_busy_cleared"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        step = '0;
        count = '0;
        theta_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", theta_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_theta", theta, 0);
        chk("rst_idx", theta_idx, 0);
        chk("rst_last", theta_last, 0);
        rst = 1'b0;
        tick();

        // Quarter-turn steps.
        exp_th[0] = 0; exp_th[1] = 25; exp_th[2] = -50; exp_th[3] = -25;
        run_stream("t1", 12'd1024, 8'd4, 1'b0);

        // Eighth-turn steps, full wrap.
        exp_th[0] = 0;   exp_th[1] = 13;  exp_th[2] = 25;  exp_th[3] = 38;
        exp_th[4] = -50; exp_th[5] = -38; exp_th[6] = -25; exp_th[7] = -13;
        run_stream("t2", 12'd512, 8'd8, 1'b0);

        // Same quarter-turn sequence under backpressure.
        exp_th[0] = 0; exp_th[1] = 25; exp_th[2] = -50; exp_th[3] = -25;
        run_stream("t3", 12'd1024, 8'd4, 1'b1);

        // count==0, with a second start while FIN.
        step  = 12'd5;
        count = 8'd0;
        start = 1'b1;
        tick();
        chk("t4_busy", busy, 1);
        chk("t4_done", done, 1);
        chk("t4_valid", theta_valid, 0);
        tick();
        start = 1'b0;
        chk("t4_busy_end", busy, 0);
        chk("t4_done_end", done, 0);
        tick();
        chk("t4_ignored_busy", busy, 0);
        chk("t4_ignored_valid", theta_valid, 0);
        chk("t4_ignored_done", done, 0);

        // -1 LSB step: tiny negative angles round to zero.
        exp_th[0] = 0; exp_th[1] = 0; exp_th[2] = 0;
        run_stream("t5", 12'd4095, 8'd3, 1'b0);

        // Reset after two handshakes of a count=8 run.
        step  = 12'd1024;
        count = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_pre_idx", theta_idx, 2);
        chk("t6_pre_theta", theta, -50);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", theta_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_idx", theta_idx, 0);
        rst = 1'b0;
        tick();
        chk("t6_idle_done", done, 0);
        exp_th[0] = 0; exp_th[1] = 25; exp_th[2] = -50; exp_th[3] = -25;
        run_stream("t6_restart", 12'd1024, 8'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
